// File: rtl/fold_remover_sched.sv
// ---------------------------------------------------------------------------
// fold_remover_sched
//
// Round-robin scheduler that time-shares a single fold_remover between
// CHANNELS frame producers. A granted channel's frame of J+1 folded samples
// is latched into fr_in. The remover is then given a clean reset, a one-cycle
// en pulse and a fixed settle window. Its output is captured into result and
// returned with a one-cycle ack to the owning channel.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high
//   req           per-channel request, held until the matching ack bit
//   frame_in      all channel frames; channel c sample k occupies
//                 bits [(c*(J+1)+k)*OUT_RES +: OUT_RES]
//   ack           one-hot, one-cycle completion pulse
//   result        captured unfolded frame (sample k at [k*OUT_RES +: OUT_RES])
//   result_valid  one-cycle pulse coincident with ack
//   result_ch     channel index owning result
//   busy          high in every non-IDLE state
//   fr_reset      reset to the attached fold_remover
//   fr_en         start pulse to the attached fold_remover
//   fr_in         latched frame driven to the fold_remover
//   fr_out        fold_remover output frame
//
// Samples are two's-complement OUT_RES-bit values packed into flat vectors;
// the scheduler only moves them, so no arithmetic depends on signedness.
// ---------------------------------------------------------------------------
module fold_remover_sched #(
    parameter int J        = 18,
    parameter int OUT_RES  = 16,
    parameter int CHANNELS = 2,
    parameter int SETTLE   = J + 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [CHANNELS-1:0]               req,
    input  logic [CHANNELS*(J+1)*OUT_RES-1:0] frame_in,
    output logic [CHANNELS-1:0]               ack,
    output logic [(J+1)*OUT_RES-1:0]          result,
    output logic                              result_valid,
    output logic [2:0]                        result_ch,
    output logic                              busy,
    output logic                              fr_reset,
    output logic                              fr_en,
    output logic [(J+1)*OUT_RES-1:0]          fr_in,
    input  logic [(J+1)*OUT_RES-1:0]          fr_out
);

    localparam int FRAME_W = (J + 1) * OUT_RES;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;

    localparam logic [5:0] CNT_LAST  = 6'(SETTLE - 1);
    localparam logic [2:0] LAST_INIT = 3'(CHANNELS - 1);

    logic [2:0]         state;
    logic [2:0]         grant;
    logic [2:0]         last_grant;
    logic [5:0]         cnt;

    logic [7:0]         req_pad;
    logic               pick_valid;
    logic [2:0]         pick;
    logic [3:0]         cand;
    logic [FRAME_W-1:0] sel_frame;
    logic [7:0]         ack_onehot;

    // Widen req to a fixed 8 bits so the 3-bit channel index can address it
    // for any CHANNELS in 2..8.
    always_comb begin
        req_pad                 = '0;
        req_pad[CHANNELS-1:0]   = req;
    end

    // Round-robin: scan channels last_grant+1, last_grant+2, ... cyclically,
    // so the most recently served channel is considered last.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            cand = {1'b0, last_grant} + 4'(i);
            if (cand >= 4'(CHANNELS)) begin
                cand = cand - 4'(CHANNELS);
            end
            if (!pick_valid && req_pad[cand[2:0]]) begin
                pick_valid = 1'b1;
                pick       = cand[2:0];
            end
        end
    end

    // Frame of the channel about to be granted.
    always_comb begin
        sel_frame = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (pick == 3'(c)) begin
                sel_frame = frame_in[c*FRAME_W +: FRAME_W];
            end
        end
    end

    always_comb begin
        ack_onehot = 8'd1 << grant;
    end

    // Control outputs are gated by reset so that fr_en and fr_reset can never
    // coincide, even if reset arrives while the FSM sits in START.
    assign busy     = (state != S_IDLE) && !reset;
    assign fr_en    = (state == S_START) && !reset;
    assign fr_reset = reset || (state == S_LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            grant        <= '0;
            last_grant   <= LAST_INIT;
            cnt          <= '0;
            fr_in        <= '0;
            result       <= '0;
            result_ch    <= '0;
            result_valid <= 1'b0;
            ack          <= '0;
        end else begin
            // ack/result_valid are single-cycle pulses by default.
            ack          <= '0;
            result_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant <= pick;
                        fr_in <= sel_frame;
                        state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    state <= S_START;
                end

                S_START: begin
                    cnt   <= '0;
                    state <= S_RUN;
                end

                S_RUN: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == CNT_LAST) begin
                        state <= S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    result       <= fr_out;
                    result_ch    <= grant;
                    last_grant   <= grant;
                    ack          <= ack_onehot[CHANNELS-1:0];
                    result_valid <= 1'b1;
                    state        <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
